// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS/DIV registers, TX FIFO, 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module bus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_re,
    input  logic [3:0]  bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        uart_tx
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_STOP
    } state_t;
`endif

    // Bus decode
    logic       addr_hit;
    logic [1:0] reg_sel;
    logic       push_req;
    logic       status_rd;
    logic       unused_bits;

    assign addr_hit    = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel     = bus_addr[3:2];
    assign push_req    = addr_hit && (reg_sel == 2'd0) && bus_we[0];
    assign status_rd   = bus_re && addr_hit && (reg_sel == 2'd1);
    assign unused_bits = ^{bus_we[3:2], bus_wdata[31:16], bus_addr[1:0]};

    // Registers
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bit_div_q, bit_div_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // FIFO storage: no reset, so it maps onto distributed/block RAM
    logic [7:0] fifo_mem [FIFO_DEPTH];
    logic [7:0] fifo_rdata;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push_ok;
    logic       overflow;

    assign fifo_rdata = fifo_mem[rd_ptr_q[AW-1:0]];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken
    assign push_ok    = push_req && (!fifo_full || pop);
    assign overflow   = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= bus_wdata[7:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Register writes; an overflow in the same cycle as a STATUS read stays visible
    always_comb begin
        div_d = div_q;
        if (addr_hit && (reg_sel == 2'd2)) begin
            if (bus_we[0]) div_d[7:0]  = bus_wdata[7:0];
            if (bus_we[1]) div_d[15:8] = bus_wdata[15:8];
        end
        ovf_d = (ovf_q && !status_rd) || overflow;
    end

    // Bit period is latched per frame so DIV writes never stretch a bit in flight
    logic [15:0] eff_div;
    logic        bit_end;

    assign eff_div = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bit_end = (cnt_q == (bit_div_q - 16'd1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_div_d = bit_div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    cnt_d   = 16'd0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    cnt_d = 16'd0;
                    // Chain straight into the next start bit when more data is queued
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            shift_d   = fifo_rdata;
            bit_div_d = eff_div;
            cnt_d     = 16'd0;
            bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_rdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            bit_div_q <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            div_q     <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_div_q <= bit_div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            div_q     <= div_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // Read mux is purely combinational from bus_re/bus_addr
    logic busy;
    assign busy = (state_q != ST_IDLE);

    always_comb begin
        bus_rdata = 32'd0;
        if (bus_re && addr_hit) begin
            case (reg_sel)
                2'd1:    bus_rdata = {27'd0, ovf_q, fifo_full, fifo_empty, busy, 1'b0};
                2'd2:    bus_rdata = {16'd0, div_q};
                default: bus_rdata = 32'd0;
            endcase
        end
    end

    assign uart_tx = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed self-checking bench for bus_uart_tx (FIFO_DEPTH=4 instance).
// Build with +define+UART_TX_PARITY_EN to exercise the parity framing.
module tb_bus_uart_tx;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_re;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_uart_tx #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd868)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus_re   (bus_re),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .uart_tx  (uart_tx)
    );

    // Expected line levels of one frame, index 0 = start bit
    function automatic logic [10:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    // Bus tasks are entered and left on a falling edge
    task automatic bus_write(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] data);
        bus_addr  = addr;
        bus_we    = we;
        bus_wdata = data;
        @(negedge clk);
        bus_we    = 4'd0;
        $display("write addr=%08h we=%b data=%08h", addr, we, data);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_addr = addr;
        bus_re   = 1'b1;
        #1 data  = bus_rdata;
        @(negedge clk);
        bus_re   = 1'b0;
        $display("read  addr=%08h data=%08h", addr, data);
    endtask

    task automatic wait_idle(input int max_cycles, output logic [31:0] st);
        int n = 0;
        bus_read(BASE + 32'h4, st);
        while (st !== 32'h4 && n < max_cycles) begin
            bus_read(BASE + 32'h4, st);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_held: got %b want 1", uart_tx); end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_release: got %b want 1", uart_tx); end
        bus_read(BASE + 32'h4, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL reset_status: got %08h want 00000004", rd); end
        bus_read(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h364) begin errors++; $display("FAIL reset_div: got %08h want 00000364", rd); end
        bus_read(BASE + 32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL data_reads_zero: got %08h want 0", rd); end
        bus_read(BASE + 32'hC, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reserved_reads_zero: got %08h want 0", rd); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        bus_addr = BASE + 32'h4;
        bus_re   = 1'b0;
        #1;
        checks++;
        if (bus_rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_re: got %08h want 0", bus_rdata); end
        bus_read(BASE + 32'h14, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL miss_read: got %08h want 0", rd); end
        bus_write(BASE + 32'h10, 4'hF, 32'h0000_0055);
        bus_write(BASE, 4'b1110, 32'hFFFF_FF66);
        bus_write(BASE + 32'hC, 4'hF, 32'h0000_1234);
        repeat (3) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL no_push_tx: got %b want 1", uart_tx); end
        bus_read(BASE + 32'h4, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL no_push_status: got %08h want 00000004", rd); end
        bus_write(BASE + 32'h8, 4'b0011, 32'hABCD_1234);
        bus_read(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h1234) begin errors++; $display("FAIL div_full: got %08h want 00001234", rd); end
        bus_write(BASE + 32'h8, 4'b0001, 32'h0000_00FF);
        bus_read(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h12FF) begin errors++; $display("FAIL div_lane0: got %08h want 000012FF", rd); end
        bus_write(BASE + 32'h8, 4'b0010, 32'h0000_5600);
        bus_read(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h56FF) begin errors++; $display("FAIL div_lane1: got %08h want 000056FF", rd); end
        bus_write(BASE + 32'h8, 4'b1100, 32'hFFFF_0000);
        bus_read(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h56FF) begin errors++; $display("FAIL div_upper_lanes: got %08h want 000056FF", rd); end
    endtask

    // 0x48 at DIV=4: start falls two edges after the write edge, 4 clocks per bit
    task automatic test_frame();
        logic [10:0] exp;
        logic [31:0] st;
        int bad = 0;
        exp = frame_of(8'h48);
        bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0004);
        bus_write(BASE, 4'b0001, 32'h0000_0048);
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_pre_start: got %b want 1", uart_tx); end
        for (int i = 0; i < FRAME_BITS * 4; i++) begin
            @(negedge clk);
            checks++;
            if (uart_tx !== exp[i / 4]) begin
                errors++;
                bad++;
                $display("FAIL frame_bit: cycle %0d got %b want %b", i, uart_tx, exp[i / 4]);
            end
            if (i == 20) begin
                bus_addr = BASE + 32'h4;
                bus_re   = 1'b1;
                #1 st    = bus_rdata;
                bus_re   = 1'b0;
                checks++;
                if (st !== 32'h6) begin errors++; $display("FAIL frame_busy: got %08h want 00000006", st); end
            end
        end
        $display("frame 0x48 sampled, %0d bad cycles", bad);
        bus_read(BASE + 32'h4, st);
        checks++;
        if (st !== 32'h4) begin errors++; $display("FAIL frame_idle_after: got %08h want 00000004", st); end
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL frame_line_idle: got %b want 1", uart_tx); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0064);
        for (int i = 0; i < 6; i++) begin
            bus_write(BASE, 4'b0001, 32'h11 + i);
        end
        bus_read(BASE + 32'h4, rd);
        checks++;
        if (rd !== 32'h1A) begin errors++; $display("FAIL ovf_status: got %08h want 0000001A", rd); end
        bus_read(BASE + 32'h4, rd);
        checks++;
        if (rd !== 32'h0A) begin errors++; $display("FAIL ovf_cleared: got %08h want 0000000A", rd); end
        bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0001);
        wait_idle(3000, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL ovf_drain: got %08h want 00000004", rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  msg [12];
        logic [31:0] rd;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0A};
        bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0002);
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [31:0] st;
                    int guard;
                    guard    = 0;
                    bus_addr = BASE + 32'h4;
                    bus_re   = 1'b1;
                    #1 st    = bus_rdata;
                    bus_re   = 1'b0;
                    while (st[3] && guard < 400) begin
                        @(negedge clk);
                        guard++;
                        bus_addr = BASE + 32'h4;
                        bus_re   = 1'b1;
                        #1 st    = bus_rdata;
                        bus_re   = 1'b0;
                    end
                    if (st[3]) begin
                        checks++;
                        errors++;
                        $display("FAIL b2b_fifo_stuck_full: byte %0d status %08h", i, st);
                    end
                    bus_write(BASE, 4'b0001, {24'd0, msg[i]});
                end
            end
            begin
                logic [10:0] bits;
                logic [10:0] exp;
                int w;
                w    = 0;
                bits = '0;
                while (uart_tx !== 1'b0 && w < 200) begin
                    @(negedge clk);
                    w++;
                end
                checks++;
                if (uart_tx !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_start_timeout: got %b want 0", uart_tx);
                end else begin
                    // Fixed 2-clock stride across all frames: any idle gap shifts a start bit to 1
                    for (int f = 0; f < 12; f++) begin
                        for (int k = 0; k < FRAME_BITS; k++) begin
                            bits[k] = uart_tx;
                            @(negedge clk);
                            @(negedge clk);
                        end
                        exp = frame_of(msg[f]);
                        checks++;
                        if (bits[FRAME_BITS-1:0] !== exp[FRAME_BITS-1:0]) begin
                            errors++;
                            $display("FAIL b2b_frame: frame %0d got %b want %b", f,
                                     bits[FRAME_BITS-1:0], exp[FRAME_BITS-1:0]);
                        end else begin
                            $display("b2b frame %0d byte %02h ok", f, msg[f]);
                        end
                    end
                end
            end
        join
        wait_idle(400, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL b2b_idle: got %08h want 00000004", rd); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        int high = 0;
        bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0004);
        bus_write(BASE, 4'b0001, 32'h0000_0000);
        bus_write(BASE, 4'b0001, 32'h0000_00AA);
        bus_write(BASE, 4'b0001, 32'h0000_0055);
        repeat (8) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_frame_data_low: got %b want 0", uart_tx); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", uart_tx); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_read(BASE + 32'h4, rd);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL post_reset_status: got %08h want 00000004", rd); end
        bus_read(BASE + 32'h8, rd);
        checks++;
        if (rd !== 32'h364) begin errors++; $display("FAIL post_reset_div: got %08h want 00000364", rd); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b1) high++;
        end
        checks++;
        if (high != 30) begin errors++; $display("FAIL queue_flushed: high %0d of 30 cycles want 30", high); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic capture_frame(output logic [10:0] bits, output logic seen);
        int w = 0;
        bits = '0;
        while (uart_tx !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        seen = (uart_tx === 1'b0);
        if (seen) begin
            for (int k = 0; k < FRAME_BITS; k++) begin
                bits[k] = uart_tx;
                @(negedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_parity();
        logic [10:0] bits;
        logic        seen;
        bus_write(BASE + 32'h8, 4'b0011, 32'h0000_0002);
        bus_write(BASE, 4'b0001, 32'h0000_0007);
        capture_frame(bits, seen);
        checks++;
        if (!seen || bits !== 11'b110_0000_1110) begin
            errors++;
            $display("FAIL parity_07: got %b want 11000001110", bits);
        end
        bus_write(BASE, 4'b0001, 32'h0000_0003);
        capture_frame(bits, seen);
        checks++;
        if (!seen || bits !== 11'b100_0000_0110) begin
            errors++;
            $display("FAIL parity_03: got %b want 10000000110", bits);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        bus_re    = 1'b0;
        bus_we    = 4'd0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        test_decode();
        test_frame();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1000_0000, meaning peripheral base address; decode compares bus_addr[31:4].
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning TX FIFO entries (power of two, 2..256).
REQ-003 SHALL have parameter DEFAULT_DIV, default 16'd868, meaning reset value of the baud divisor.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port bus_re, input, 1, meaning read strobe from CPU core.
REQ-007 SHALL have port bus_we, input, 4, meaning byte-lane write strobes; bit i enables wdata[8i+7:8i].
REQ-008 SHALL have port bus_addr, input, 32, meaning byte address.
REQ-009 SHALL have port bus_wdata, input, 32, meaning write data.
REQ-010 SHALL have port bus_rdata, output, 32, meaning read data, combinational from bus_re/bus_addr.
REQ-011 SHALL have port uart_tx, output, 1, meaning serial line, idle high.

Function
REQ-012 SHALL respond only when bus_addr[31:4]==BASE_ADDR[31:4]; offset bus_addr[3:2]: 0=DATA, 1=STATUS, 2=DIV, 3=reserved (reads 0, writes ignored).
REQ-013 SHALL push bus_wdata[7:0] into FIFO when DATA hit and bus_we[0]=1; other lanes ignored.
REQ-014 SHALL, on DATA push while FIFO full and no pop that cycle, drop the byte and set sticky OVF; push and pop in the same cycle when full SHALL be accepted.
REQ-015 SHALL return STATUS = {27'b0, OVF[4], FULL[3], EMPTY[2], BUSY[1], 1'b0}; BUSY=FSM not IDLE.
REQ-016 SHALL clear OVF on the rising edge ending a cycle in which bus_re=1 and STATUS hit.
REQ-017 SHALL write DIV[15:0] per lanes bus_we[1:0]; DIV reads zero-extended; DATA reads 0.
REQ-018 SHALL drive bus_rdata=0 when bus_re=0 or no address hit.
REQ-019 SHALL implement FSM IDLE, START, DATA, PARITY (macro only), STOP; each bit lasts max(DIV,1) clk cycles, DIV latched into a bit counter at frame start (mid-frame DIV writes affect next frame).
REQ-020 SHALL, in IDLE with FIFO non-empty, pop one byte and enter START on the next edge; uart_tx falls at the second rising edge after the write edge when FIFO was empty.
REQ-021 SHALL send DATA LSB first, 8 bits, then one stop bit (1).
REQ-022 SHALL go STOP->START directly, popping, when FIFO non-empty at stop-bit end (zero idle gap); else STOP->IDLE.
REQ-023 SHALL drive uart_tx=1 in IDLE and STOP.

Reset
REQ-024 SHALL on rst_n=0 immediately: uart_tx=1, FSM=IDLE, FIFO empty (pointers 0), OVF=0, DIV=DEFAULT_DIV, bit/cycle counters 0; mid-frame reset aborts frame, queued bytes lost.

Configuration
REQ-025 SHALL, with UART_TX_PARITY_EN defined, insert PARITY state between DATA and STOP sending even parity (XOR of 8 data bits), frame = 11 bits.
REQ-026 SHALL, without UART_TX_PARITY_EN, omit PARITY state and logic, frame = 10 bits.

Verification
REQ-027 Reset release -> uart_tx=1; read BASE+4 -> bus_rdata=32'h4.
REQ-028 DIV=4, write 0x48 to BASE+0 -> uart_tx low 4 cycles from second edge after write, then 0,0,0,1,0,0,1,0 at 4 cycles each, stop high 4 cycles; BUSY=1 during frame.
REQ-029 FIFO_DEPTH=4, DIV=100, write 6 bytes back-to-back -> first popped, 4 queued, 6th dropped; STATUS=32'h1A (OVF, FULL, BUSY); second STATUS read shows OVF=0.
REQ-030 Write "Hello World\n" (12 bytes), DIV=2 -> 12 contiguous 10-bit frames, no idle cycles between stop and next start, bytes match in order.
REQ-031 Assert rst_n mid-DATA bit -> uart_tx=1 same cycle, STATUS=32'h4 after release, DIV=DEFAULT_DIV.
REQ-032 With UART_TX_PARITY_EN, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0.
